pwm_output_sequencer: RTL

- Run-time controller for one PWM channel.
- Sequences the PWM counter run signal and the two-bit output-enable word seen by the pin stage.
- Starts, stops and trips the channel only on period boundaries or on fault, so a run never begins or ends with a truncated pulse.
- Sits between the register/control interface and the PWM counter plus pin-control datapath.

---
 rtl/pwm_seq_pkg.sv | 33 +++
 rtl/pwm_output_sequencer_if.sv | 41 ++++
 rtl/sync_watchdog.sv | 35 +++
 rtl/pwm_output_sequencer.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_seq_pkg
//  Description : Shared state encodings, fault-cause bit positions and
//                debug-state width for the PWM output sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_seq_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] STATE_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] STATE_ARM      = 3'd1;
  localparam logic [STATE_W-1:0] STATE_RUN      = 3'd2;
  localparam logic [STATE_W-1:0] STATE_STOPPING = 3'd3;
  localparam logic [STATE_W-1:0] STATE_DRAIN    = 3'd4;
  localparam logic [STATE_W-1:0] STATE_FAULT    = 3'd5;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = STATE_IDLE,
    ST_ARM      = STATE_ARM,
    ST_RUN      = STATE_RUN,
    ST_STOPPING = STATE_STOPPING,
    ST_DRAIN    = STATE_DRAIN,
    ST_FAULT    = STATE_FAULT
  } state_e;

  // fault_cause bit positions
  localparam int FAULT_EXT_BIT = 0;
  localparam int FAULT_TMO_BIT = 1;

endpackage
`default_nettype wire

// File: rtl/pwm_output_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_output_sequencer_if
//  Description : Control/status bundle between the register interface
//                (master) and the PWM output sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_output_sequencer_if
  import pwm_seq_pkg::*;
#(
  parameter int ARM_WIDTH = 8
);
  logic                 start;
  logic                 stop;
  logic                 fault_in;
  logic                 fault_clear;
  logic                 period_sync;
  logic [1:0]           requested_outputs;
  logic [ARM_WIDTH-1:0] arm_periods;
  logic [1:0]           enable_outputs;
  logic                 counter_run;
  logic                 busy;
  logic                 fault_latched;
  logic [1:0]           fault_cause;
  logic [STATE_W-1:0]   state_out;

  modport master (
    output start, stop, fault_in, fault_clear, period_sync,
           requested_outputs, arm_periods,
    input  enable_outputs, counter_run, busy, fault_latched,
           fault_cause, state_out
  );

  modport slave (
    input  start, stop, fault_in, fault_clear, period_sync,
           requested_outputs, arm_periods,
    output enable_outputs, counter_run, busy, fault_latched,
           fault_cause, state_out
  );
endinterface
`default_nettype wire

// File: rtl/sync_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : sync_watchdog
//  Description : Saturating counter that flags a missing period_sync when it
//                reaches SYNC_TIMEOUT clocks without being cleared.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_watchdog #(
  parameter int                       TIMEOUT_WIDTH = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] SYNC_TIMEOUT  = 16'hFFFF
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic clear,
  input  wire logic count_en,
  output logic      expired
);

  logic [TIMEOUT_WIDTH-1:0] count;

  // Clear wins over counting; the count parks at SYNC_TIMEOUT once reached.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && (count != SYNC_TIMEOUT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == SYNC_TIMEOUT);

endmodule
`default_nettype wire

// File: rtl/pwm_output_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_output_sequencer
//  Description : Run-time controller for one PWM channel. Starts, stops and
//                trips the counter/pin stage only on period boundaries or on
//                fault so no truncated pulse is ever emitted.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_output_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int                       TIMEOUT_WIDTH = 16,
  parameter logic [TIMEOUT_WIDTH-1:0] SYNC_TIMEOUT  = 16'hFFFF,
  parameter int                       ARM_WIDTH     = 8
) (
  input  wire logic clock,
  input  wire logic reset,
  pwm_output_sequencer_if.slave bus
);

  state_e               state, next_state;
  logic [ARM_WIDTH-1:0] arm_cnt, arm_cnt_next;
  logic [1:0]           req_q, req_next;
  logic [1:0]           cause_q, cause_next;
  logic [1:0]           enable_q, enable_next;
  logic                 run_q, run_next;
  logic                 busy_q, fault_q;

  logic                 wd_active;
  logic                 wd_expired;
  logic                 wd_clear;
  logic                 wd_timeout;
  logic                 fault_now;

  // The watchdog only guards states that are waiting for a period boundary.
  assign wd_active  = (state == ST_ARM) || (state == ST_STOPPING) || (state == ST_DRAIN);
  assign wd_timeout = wd_active && wd_expired;
  assign fault_now  = bus.fault_in || wd_timeout;
  assign wd_clear   = bus.period_sync || (next_state != state);

  sync_watchdog #(
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH),
    .SYNC_TIMEOUT  (SYNC_TIMEOUT)
  ) u_sync_watchdog (
    .clock    (clock),
    .reset    (reset),
    .clear    (wd_clear),
    .count_en (wd_active),
    .expired  (wd_expired)
  );

  // Next-state, arm counter, request latch and fault-cause decisions.
  // Priority: fault > stop > period_sync progression > start.
  always_comb begin
    next_state   = state;
    arm_cnt_next = arm_cnt;
    req_next     = req_q;
    cause_next   = cause_q;

    if (bus.fault_in) cause_next[FAULT_EXT_BIT] = 1'b1;
    if (wd_timeout)   cause_next[FAULT_TMO_BIT] = 1'b1;

    if (state == ST_FAULT) begin
      if (bus.fault_clear && !bus.fault_in) begin
        next_state = ST_IDLE;
        cause_next = '0;
      end
    end else if (fault_now) begin
      next_state = ST_FAULT;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.stop) begin
            next_state   = ST_ARM;
            req_next     = bus.requested_outputs;
            arm_cnt_next = '0;
          end
        end
        ST_ARM: begin
          if (bus.stop) begin
            next_state = ST_DRAIN;
          end else if (bus.period_sync) begin
            if (arm_cnt == bus.arm_periods) begin
              next_state = ST_RUN;
            end else begin
              arm_cnt_next = arm_cnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (bus.stop) next_state = ST_STOPPING;
        end
        ST_STOPPING: begin
          if (bus.period_sync) next_state = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (bus.period_sync) next_state = ST_IDLE;
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

  // Output values follow the current state one edge late, except that the
  // boundary-aligned shutdown steps (STOPPING->DRAIN, DRAIN->IDLE) apply
  // on the transition edge itself.
  always_comb begin
    enable_next = 2'b00;
    run_next    = 1'b0;
    case (state)
      ST_ARM: begin
        run_next = 1'b1;
      end
      ST_RUN: begin
        enable_next = req_q;
        run_next    = 1'b1;
      end
      ST_STOPPING: begin
        enable_next = (next_state == ST_DRAIN) ? 2'b00 : req_q;
        run_next    = 1'b1;
      end
      ST_DRAIN: begin
        run_next = (next_state != ST_IDLE);
      end
      default: begin
        enable_next = 2'b00;
        run_next    = 1'b0;
      end
    endcase
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      arm_cnt  <= '0;
      req_q    <= 2'b00;
      cause_q  <= 2'b00;
      enable_q <= 2'b00;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state    <= next_state;
      arm_cnt  <= arm_cnt_next;
      req_q    <= req_next;
      cause_q  <= cause_next;
      enable_q <= enable_next;
      run_q    <= run_next;
      busy_q   <= (next_state != ST_IDLE) && (next_state != ST_FAULT);
      fault_q  <= (next_state == ST_FAULT);
    end
  end

  assign bus.enable_outputs = enable_q;
  assign bus.counter_run    = run_q;
  assign bus.busy           = busy_q;
  assign bus.fault_latched  = fault_q;
  assign bus.fault_cause    = cause_q;
  assign bus.state_out      = state;

endmodule
`default_nettype wire
